mult_booth_seq: RTL and testbench

- Iterative signed 32x32 multiplier using radix-2 Booth recoding.
- Sits directly around the team's 32-bit adder (csa_32b_by_rca: sum, c_out, ovf, a, b, c_in). Each cycle it feeds the adder one partial-product add or subtract, then consumes the adder's sum and ovf.
- Produces the low 32 bits of the product plus a signed-overflow exception.
- Feeds the ALU/multdiv result path of the processor.

---
 rtl/mult_booth_seq.sv | 147 ++++++++++++++
 tb/tb_mult_booth_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: iterative signed 32x32 radix-2 Booth multiplier built around a 32-bit ripple adder.
// Revision: 1.0
`default_nettype none

module csa_32b_by_rca (
    output logic [31:0] sum,
    output logic        c_out,
    output logic        ovf,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in
);
    logic [32:0] w_c;

    assign w_c[0] = c_in;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit
            assign sum[gi]   = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = w_c[32];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf   = w_c[32] ^ w_c[31];
endmodule

module mult_booth_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_s;
    logic [WIDTH-1:0] w_new_hi;
    logic [WIDTH-1:0] w_new_lo;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_unused_cout;

    always_comb begin
        w_b   = '0;
        w_cin = 1'b0;
        case ({r_lo[0], r_q})
            2'b01:   w_b = r_m;
            2'b10: begin
                w_b   = ~r_m;
                w_cin = 1'b1;
            end
            default: w_b = '0;
        endcase
    end

    csa_32b_by_rca u_adder (
        .sum   (w_sum),
        .c_out (w_cout),
        .ovf   (w_ovf),
        .a     (r_hi),
        .b     (w_b),
        .c_in  (w_cin)
    );

    // The true 33-bit sign survives even when the 32-bit sum wraps (e.g. M = 0x80000000).
    assign w_s           = w_sum[WIDTH-1] ^ w_ovf;
    assign w_new_hi      = {w_s, w_sum[WIDTH-1:1]};
    assign w_new_lo      = {w_sum[0], r_lo[WIDTH-1:1]};
    assign w_cnt_nxt     = r_cnt + 1'b1;
    assign w_unused_cout = w_cout;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_m            <= '0;
            r_hi           <= '0;
            r_lo           <= '0;
            r_q            <= 1'b0;
            r_cnt          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ctrl_MULT) begin
                        r_m     <= data_operandA;
                        r_hi    <= '0;
                        r_lo    <= data_operandB;
                        r_q     <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_hi  <= w_new_hi;
                    r_lo  <= w_new_lo;
                    r_q   <= r_lo[0];
                    r_cnt <= w_cnt_nxt;
                    if (r_cnt == C_LAST) begin
                        data_result    <= w_new_lo;
                        // Product fits in 32 signed bits only if HI is pure sign extension of LO.
                        data_exception <= (w_new_hi != {WIDTH{w_sum[0]}});
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    data_resultRDY <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mult_booth_seq.sv
// tb_mult_booth_seq: directed vector table plus hand-written start-ignore and mid-run reset sequences.
// Revision: 1.0
`default_nettype none

module tb_mult_booth_seq;
    logic        clock;
    logic        resetn;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[12];

    mult_booth_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts an operation, then scrambles the operand inputs to prove they were captured.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Waits for the RDY pulse; returns the edge number (relative to start) at which it appeared.
    task automatic wait_rdy(output int edge_n, output logic busy_ok);
        edge_n  = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (n < 32 && busy !== 1'b1) busy_ok = 1'b0;
            if (data_resultRDY === 1'b1) begin
                edge_n = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e);
        int   edge_n;
        logic busy_ok;
        pulse_start(a, b);
        wait_rdy(edge_n, busy_ok);
        check({name, " rdy_edge"}, 32'(edge_n), 32'd32);
        check({name, " busy_run"}, {31'd0, busy_ok}, 32'd1);
        check({name, " result"}, data_result, exp_r);
        check({name, " exc"}, {31'd0, data_exception}, {31'd0, exp_e});
        check({name, " busy_done"}, {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        check({name, " rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int   edge_n;
        logic busy_ok;
        logic saw_rdy;

        vecs[0]  = '{a: 32'd3,          b: 32'd5,          r: 32'h0000000F, e: 1'b0};
        vecs[1]  = '{a: 32'hFFFFFFF9,   b: 32'd6,          r: 32'hFFFFFFD6, e: 1'b0};
        vecs[2]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   r: 32'h80000000, e: 1'b1};
        vecs[3]  = '{a: 32'h00010000,   b: 32'h00010000,   r: 32'h00000000, e: 1'b1};
        vecs[4]  = '{a: 32'h7FFFFFFF,   b: 32'd1,          r: 32'h7FFFFFFF, e: 1'b0};
        vecs[5]  = '{a: 32'h80000000,   b: 32'd1,          r: 32'h80000000, e: 1'b0};
        vecs[6]  = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   r: 32'h00000001, e: 1'b0};
        vecs[7]  = '{a: 32'h80000000,   b: 32'h80000000,   r: 32'h00000000, e: 1'b1};
        vecs[8]  = '{a: 32'h12345678,   b: 32'h00000010,   r: 32'h23456780, e: 1'b1};
        vecs[9]  = '{a: 32'd46341,      b: 32'd46341,      r: 32'h80001219, e: 1'b1};
        vecs[10] = '{a: 32'd46340,      b: 32'd46340,      r: 32'h7FFEA810, e: 1'b0};
        vecs[11] = '{a: 32'hFFFFFFFD,   b: 32'hFFFFFFFB,   r: 32'h0000000F, e: 1'b0};

        resetn        = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exc", {31'd0, data_exception}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);

        // A new start must not clear the previous result.
        pulse_start(32'd7, 32'd7);
        check("hold result", data_result, 32'h0000000F);
        wait_rdy(edge_n, busy_ok);
        check("hold op result", data_result, 32'd49);
        @(posedge clock);

        // Second strobe mid-run is ignored: one RDY at edge 32 with 2*2.
        pulse_start(32'd2, 32'd2);
        edge_n  = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 10) begin
                data_operandA = 32'd9;
                data_operandB = 32'd9;
                ctrl_MULT     = 1'b1;
            end
            @(posedge clock);
            #1;
            if (n == 10) ctrl_MULT = 1'b0;
            if (n < 32 && busy !== 1'b1) busy_ok = 1'b0;
            if (data_resultRDY === 1'b1) begin
                edge_n = n;
                break;
            end
        end
        check("ignore rdy_edge", 32'(edge_n), 32'd32);
        check("ignore busy_run", {31'd0, busy_ok}, 32'd1);
        check("ignore result", data_result, 32'h00000004);
        saw_rdy = 1'b0;
        @(posedge clock);
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1) saw_rdy = 1'b1;
        end
        check("ignore no_second_op", {31'd0, saw_rdy}, 32'd0);

        // Mid-run asynchronous reset discards the operation.
        pulse_start(32'd3, 32'd5);
        repeat (14) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst result", data_result, 32'd0);
        check("midrst exc", {31'd0, data_exception}, 32'd0);
        check("midrst rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn  = 1'b1;
        saw_rdy = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1) saw_rdy = 1'b1;
        end
        check("midrst no_rdy", {31'd0, saw_rdy}, 32'd0);
        run_op("post_reset", 32'd4, 32'd4, 32'h00000010, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
